// File: rtl/pulse_stretcher.sv
// pulse_stretcher: stretches single-cycle events into fixed-width visible pulses, queueing
// events that arrive mid-pulse and flagging the ones that do not fit.
module pulse_stretcher #(
  parameter int P_ON_TH       = 10,
  parameter int P_OFF_TH      = 10,
  parameter int P_MAX_PENDING = 3
)(
  input  logic CLK,
  input  logic RST_N,
  input  logic in,
  output logic out,
  output logic busy,
  output logic overflow
);
  localparam int TW = $clog2((P_ON_TH > P_OFF_TH ? P_ON_TH : P_OFF_TH) + 1);
  localparam int PW = $clog2(P_MAX_PENDING + 1);
  localparam logic [TW-1:0] T_ON  = TW'(P_ON_TH - 1);
  localparam logic [TW-1:0] T_OFF = TW'(P_OFF_TH - 1);
  localparam logic [PW-1:0] P_MAX = PW'(P_MAX_PENDING);
  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;
  state_t          state;
  logic [TW-1:0]   timer;
  logic [PW-1:0]   pending;
  logic            expired;
  logic            full;
  logic            gap_end;
  assign expired = timer == '0;
  assign full    = pending == P_MAX;
  assign gap_end = state == OFF && expired;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      timer    <= '0;
      pending  <= '0;
      out      <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= 1'b0;
      // at the end of a gap the event (queued or fresh) is consumed, so it never queues there
      if (state != IDLE && !gap_end && in) begin
        if (full) overflow <= 1'b1;
        else      pending  <= pending + PW'(1);
      end
      if (state == IDLE) begin
        if (in) begin
          state <= ON;
          timer <= T_ON;
          out   <= 1'b1;
          busy  <= 1'b1;
        end
      end else if (!expired) begin
        timer <= timer - TW'(1);
      end else if (state == ON) begin
        state <= OFF;
        timer <= T_OFF;
        out   <= 1'b0;
      end else if (pending != '0 || in) begin
        state <= ON;
        timer <= T_ON;
        out   <= 1'b1;
        if (pending != '0) pending <= pending - PW'(!in);
      end else begin
        state <= IDLE;
        busy  <= 1'b0;
      end
    end
  end
endmodule
